// File: rtl/root_pkg.sv
// rtl/root_pkg.sv - shared mode constants, FSM states and sizing helper for int_root
package root_pkg;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CUBE = 1'b1;

  typedef enum logic [2:0] {IDLE, SHIFT, MUL, CMP, DONE} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-add multiplier; start at edge n gives product and busy low at edge n+AW
module seq_mul #(
  parameter int AW = 4,
  parameter int BW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [AW-1:0]     a_bi,
  input  logic [BW-1:0]     b_bi,
  output logic              busy_o,
  output logic [AW+BW-1:0]  y_bo
);

  localparam int PW   = AW + BW;
  localparam int CNTW = $clog2(AW + 1);

  logic [PW-1:0]   mcand_q;
  logic [AW-1:0]   mplier_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o   <= 1'b0;
      y_bo     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (!busy_o) begin
      if (start_i) begin
        busy_o   <= 1'b1;
        y_bo     <= '0;
        mcand_q  <= PW'(b_bi);
        mplier_q <= a_bi;
        cnt_q    <= CNTW'(AW - 1);
      end
    end else begin
      // one multiplier bit per cycle, LSB first
      if (mplier_q[0]) y_bo <= y_bo + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) busy_o <= 1'b0;
      else             cnt_q  <= cnt_q - CNTW'(1);
    end
  end

endmodule

// File: rtl/int_root.sv
// rtl/int_root.sv - sequential floor sqrt/cbrt, digit-by-digit restoring; INT_ROOT_REMAINDER_EN adds rem_bo
module int_root
  import root_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int YW    = (WIDTH + 1) / 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic [YW-1:0]    y_bo
`ifdef INT_ROOT_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] rem_bo
`endif
);

  localparam int PW = 2 * YW + 1;
  localparam int CW = 2 * YW + 3;
  localparam int BW = YW + 1;
  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(YW + 1);
  localparam logic [SW-1:0] S_TOP_SQRT = SW'(2 * (ceil_div(WIDTH, 2) - 1));
  localparam logic [SW-1:0] S_TOP_CUBE = SW'(3 * (ceil_div(WIDTH, 3) - 1));

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q;
  logic [YW-1:0]    y_q;
  logic [SW-1:0]    s_q;
  logic             mode_q;
  logic [MW-1:0]    mcnt_q;

  logic             mul_start, mul_busy;
  logic [PW-1:0]    prod;
  logic [YW-1:0]    y_sh;
  logic [BW-1:0]    b_op;
  logic [CW-1:0]    term, x_top, diff;
  logic             fits;
  logic [WIDTH-1:0] x_sub, low_mask;

  assign y_sh = y_q << 1;
  assign b_op = {1'b0, y_sh} + BW'(1);

  seq_mul #(.AW(YW), .BW(BW)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start),
    .a_bi    (y_sh),
    .b_bi    (b_op),
    .busy_o  (mul_busy),
    .y_bo    (prod)
  );

  // compare against x >> s so the shifted trial term can never overflow
  always_comb begin
    term     = (mode_q == MODE_CUBE) ? (CW'(prod) + CW'({prod, 1'b0}) + CW'(1))
                                     : CW'({y_q, 1'b1});
    x_top    = CW'(x_q >> s_q);
    fits     = (x_top >= term);
    diff     = x_top - term;
    low_mask = ~({WIDTH{1'b1}} << s_q);
    x_sub    = (WIDTH'(diff) << s_q) | (x_q & low_mask);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = SHIFT;
      SHIFT: begin
        if (mode_q == MODE_CUBE) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end else begin
          state_d = CMP;
        end
      end
      MUL:   if (mcnt_q == '0 || !mul_busy) state_d = CMP;
      CMP:   state_d = (s_q == '0) ? DONE : SHIFT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      mode_q <= MODE_SQRT;
      mcnt_q <= '0;
      y_bo   <= '0;
`ifdef INT_ROOT_REMAINDER_EN
      rem_bo <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          x_q    <= x_bi;
          mode_q <= mode_i;
          y_q    <= '0;
          s_q    <= (mode_i == MODE_CUBE) ? S_TOP_CUBE : S_TOP_SQRT;
        end
        SHIFT: begin
          y_q    <= y_sh;
          mcnt_q <= MW'(YW - 1);
        end
        MUL: if (mcnt_q != '0) mcnt_q <= mcnt_q - MW'(1);
        CMP: begin
          if (fits) begin
            x_q <= x_sub;
            y_q <= y_q | YW'(1);
          end
          if (s_q != '0) s_q <= s_q - ((mode_q == MODE_CUBE) ? SW'(3) : SW'(2));
        end
        DONE: begin
          y_bo   <= y_q;
`ifdef INT_ROOT_REMAINDER_EN
          rem_bo <= x_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_root.sv
// tb/tb_int_root.sv - scoreboard bench for int_root at WIDTH=8 and WIDTH=16
module tb_int_root;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st8 = 1'b0, md8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        busy8, done8;
  logic [3:0]  y8;
  logic        st16 = 1'b0, md16 = 1'b0;
  logic [15:0] x16 = '0;
  logic        busy16, done16;
  logic [7:0]  y16;
`ifdef INT_ROOT_REMAINDER_EN
  logic [7:0]  r8;
  logic [15:0] r16;
`endif

  int_root #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(st8), .mode_i(md8), .x_bi(x8),
    .busy_o(busy8), .done_o(done8), .y_bo(y8)
`ifdef INT_ROOT_REMAINDER_EN
    , .rem_bo(r8)
`endif
  );

  int_root #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(st16), .mode_i(md16), .x_bi(x16),
    .busy_o(busy16), .done_o(done16), .y_bo(y16)
`ifdef INT_ROOT_REMAINDER_EN
    , .rem_bo(r16)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit w16;
    bit m;
    int x;
    int y;
    int rem;
    int busy;
  } exp_t;
  exp_t sb[$];

  function automatic longint pw(input longint v, input bit m);
    return m ? v * v * v : v * v;
  endfunction

  function automatic int root_model(input bit m, input int x);
    int y = 0;
    while (pw(longint'(y + 1), m) <= longint'(x)) y++;
    return y;
  endfunction

  task automatic expect_op(input bit w16, input bit m, input int x);
    exp_t e;
    e.w16  = w16;
    e.m    = m;
    e.x    = x;
    e.y    = root_model(m, x);
    e.rem  = x - int'(pw(longint'(e.y), m));
    e.busy = w16 ? (m ? 61 : 17) : (m ? 19 : 9);
    sb.push_back(e);
  endtask

  task automatic do_op(input bit w16, input bit m, input int x,
                       output int y, output int r, output int busy_cnt,
                       output int done_cnt, output bit tmo);
    bit b, d;
    @(negedge clk);
    if (w16) begin st16 = 1'b1; md16 = m; x16 = 16'(x); end
    else     begin st8  = 1'b1; md8  = m; x8  = 8'(x);  end
    @(negedge clk);
    st16 = 1'b0;
    st8  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    tmo = 1'b1;
    for (int c = 0; c < 300; c++) begin
      b = w16 ? busy16 : busy8;
      d = w16 ? done16 : done8;
      if (d) done_cnt++;
      if (!b) begin tmo = 1'b0; break; end
      busy_cnt++;
      @(negedge clk);
    end
    y = w16 ? int'(y16) : int'(y8);
`ifdef INT_ROOT_REMAINDER_EN
    r = w16 ? int'(r16) : int'(r8);
`else
    r = -1;
`endif
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || y8 !== 4'd0 ||
        busy16 !== 1'b0 || done16 !== 1'b0 || y16 !== 8'd0) begin
      failures++;
      $display("FAIL reset_state busy8=%b done8=%b y8=%0d busy16=%b done16=%b y16=%0d want all 0",
               busy8, done8, y8, busy16, done16, y16);
    end
    rst = 1'b0;
  endtask

  task automatic test_cube8;
    int xs[3] = '{27, 26, 255};
    int y, r, bc, dc;
    bit tmo;
    exp_t e;
    foreach (xs[i]) begin
      expect_op(1'b0, 1'b1, xs[i]);
      do_op(1'b0, 1'b1, xs[i], y, r, bc, dc, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || y !== e.y) begin
        failures++;
        $display("FAIL cube8_y x=%0d got %0d want %0d tmo=%0d", e.x, y, e.y, tmo);
      end
      checks++;
      if (bc !== e.busy || dc !== 1) begin
        failures++;
        $display("FAIL cube8_timing x=%0d busy %0d want %0d, done pulses %0d want 1", e.x, bc, e.busy, dc);
      end
`ifdef INT_ROOT_REMAINDER_EN
      checks++;
      if (r !== e.rem) begin
        failures++;
        $display("FAIL cube8_rem x=%0d got %0d want %0d", e.x, r, e.rem);
      end
`endif
    end
  endtask

  task automatic test_sqrt8;
    int xs[3] = '{200, 0, 255};
    int y, r, bc, dc;
    bit tmo;
    exp_t e;
    foreach (xs[i]) begin
      expect_op(1'b0, 1'b0, xs[i]);
      do_op(1'b0, 1'b0, xs[i], y, r, bc, dc, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || y !== e.y) begin
        failures++;
        $display("FAIL sqrt8_y x=%0d got %0d want %0d tmo=%0d", e.x, y, e.y, tmo);
      end
      checks++;
      if (bc !== e.busy || dc !== 1) begin
        failures++;
        $display("FAIL sqrt8_timing x=%0d busy %0d want %0d, done pulses %0d want 1", e.x, bc, e.busy, dc);
      end
`ifdef INT_ROOT_REMAINDER_EN
      checks++;
      if (r !== e.rem) begin
        failures++;
        $display("FAIL sqrt8_rem x=%0d got %0d want %0d", e.x, r, e.rem);
      end
`endif
    end
  endtask

  task automatic test_wide16;
    int y, r, bc, dc;
    bit tmo;
    exp_t e;
    for (int m = 1; m >= 0; m--) begin
      expect_op(1'b1, 1'(m), 65535);
      do_op(1'b1, 1'(m), 65535, y, r, bc, dc, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || y !== e.y) begin
        failures++;
        $display("FAIL wide16_y mode=%0d got %0d want %0d tmo=%0d", m, y, e.y, tmo);
      end
      checks++;
      if (bc !== e.busy || dc !== 1) begin
        failures++;
        $display("FAIL wide16_timing mode=%0d busy %0d want %0d, done pulses %0d want 1", m, bc, e.busy, dc);
      end
`ifdef INT_ROOT_REMAINDER_EN
      checks++;
      if (r !== e.rem) begin
        failures++;
        $display("FAIL wide16_rem mode=%0d got %0d want %0d", m, r, e.rem);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int y, r, bc, dc;
    bit tmo;
    exp_t e;
    expect_op(1'b0, 1'b1, 27);
    do_op(1'b0, 1'b1, 27, y, r, bc, dc, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || y !== e.y) begin
      failures++;
      $display("FAIL pre_reset_y got %0d want %0d", y, e.y);
    end
    @(negedge clk);
    st8 = 1'b1; md8 = 1'b1; x8 = 8'd255;
    @(negedge clk);
    st8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || y8 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b y=%0d want 0 0 0", busy8, done8, y8);
    end
    @(negedge clk);
    rst = 1'b0;
    expect_op(1'b0, 1'b1, 26);
    do_op(1'b0, 1'b1, 26, y, r, bc, dc, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || y !== e.y || bc !== e.busy) begin
      failures++;
      $display("FAIL post_reset_op y %0d want %0d, busy %0d want %0d", y, e.y, bc, e.busy);
    end
  endtask

  task automatic test_back_to_back;
    int bc;
    bit seen;
    exp_t e;
    @(negedge clk);
    expect_op(1'b0, 1'b1, 27);
    st8 = 1'b1; md8 = 1'b1; x8 = 8'd27;
    @(negedge clk);
    bc = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy8) begin seen = 1'b1; break; end
      bc++;
      x8  = 8'($urandom);
      md8 = ~md8;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (!seen || y8 !== 4'(e.y) || bc !== e.busy) begin
      failures++;
      $display("FAIL b2b_first y %0d want %0d, busy %0d want %0d", y8, e.y, bc, e.busy);
    end
    expect_op(1'b0, 1'b0, 200);
    md8 = 1'b0; x8 = 8'd200;
    @(negedge clk);
    st8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b want 1 in cycle after idle start", busy8);
    end
    bc = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy8) begin seen = 1'b1; break; end
      bc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (!seen || y8 !== 4'(e.y) || bc !== e.busy) begin
      failures++;
      $display("FAIL b2b_second y %0d want %0d, busy %0d want %0d", y8, e.y, bc, e.busy);
    end
  endtask

  task automatic test_sweep;
    int y, r, bc, dc, x;
    bit tmo, w16;
    exp_t e;
    for (int i = 0; i < 256 + 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        w16 = (i >= 256);
        x = w16 ? (((i - 256) * 163 + (i % 7)) & 16'hFFFF) : i;
        if (i == 655) x = 65534;
        expect_op(w16, 1'(m), x);
        do_op(w16, 1'(m), x, y, r, bc, dc, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || y !== e.y) begin
          failures++;
          $display("FAIL sweep_y w16=%0d mode=%0d x=%0d got %0d want %0d", w16, m, x, y, e.y);
        end
        checks++;
        if (!(pw(longint'(y), 1'(m)) <= longint'(x) && pw(longint'(y + 1), 1'(m)) > longint'(x))) begin
          failures++;
          $display("FAIL sweep_bound w16=%0d mode=%0d x=%0d y=%0d not floor root", w16, m, x, y);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cube8();
    test_sqrt8();
    test_wide16();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
